store_align_buffer: RTL
=======================

Name: store_align_buffer

Overview:
- Store-side counterpart of the load extension path.
- Accepts MEM-stage store requests (sb/sh/sw) and generates the byte enables and lane-replicated write data.
- Detects misaligned stores.
- Queues legal stores in a small FIFO that drains to data memory over a req/ack handshake.
- Flags loads whose word address hits a pending store, so the hazard unit can stall them.

Parameters:
- DEPTH, 2, number of buffer entries; power of two, ≥2.
- CNT_W, 2, width of occupancy counter; must hold 0..DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  buffer can accept a store this cycle.
- st_addr  in  32  byte address of store.
- st_data  in  32  store data, right-justified.
- st_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- misalign_err  out  1  one-cycle pulse: the store accepted last cycle was misaligned or illegal.
- ld_valid  in  1  load in MEM stage.
- ld_addr  in  32  load byte address.
- ld_hazard  out  1  load word address matches a buffered store.
- mem_we  out  1  write request to data memory.
- mem_addr  out  30  word address (byte address [31:2]).
- mem_wdata  out  32  lane-replicated write data.
- mem_be  out  4  byte enables; bit i = byte lane i (bits [8i+7:8i]).
- mem_ack  in  1  memory accepted current write.
- empty  out  1  no stores pending; used before syscall/halt.

Behaviour:
- Reset, asynchronous on rst_n low:
  - count = 0, pointers = 0, entries invalid.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0.
  - misalign_err = 0, empty = 1, st_ready = 1.
  - A store in flight when reset asserts is dropped.
- Encoding, with a = st_addr[1:0]:
  - Byte: be = 4'b0001 << a; wdata = {4{st_data[7:0]}}; always legal.
  - Half: a = 00 gives be = 0011; a = 10 gives be = 1100; wdata = {2{st_data[15:0]}}; a[0] = 1 is misaligned.
  - Word: be = 1111; wdata = st_data; a ≠ 00 is misaligned.
  - size 11 is illegal.
- Accept = st_valid && st_ready.
  - st_ready = (count < DEPTH); combinational from registered state only.
- Accepted legal store: written to the tail entry {addr[31:2], wdata, be} at the clock edge; count increments.
- Accepted misaligned or illegal store: not enqueued; misalign_err = 1 for exactly the next cycle. Memory is never written.
- Drain:
  - mem_we = (count ≠ 0), driven from the head entry registers.
  - Earliest mem_we is the cycle after the enqueue edge (1-cycle latency).
  - mem_addr, mem_wdata and mem_be stay stable while mem_we = 1 and mem_ack = 0.
  - mem_ack with mem_we = 1: head pops at the edge and the next entry is presented the following cycle.
  - mem_ack with mem_we = 0 is ignored.
- Simultaneous accept and pop: count unchanged; FIFO order preserved.
  - When full, st_ready = 0, so a same-cycle pop does not free a slot until the next cycle (no bypass).
- Pointers wrap modulo DEPTH.
- ld_hazard = ld_valid && any valid entry has addr == ld_addr[31:2]. Combinational; includes the head currently being written.
- empty = (count == 0).

Optional Feature:
- Macro: STORE_ALIGN_MERGE_EN.
- Defined:
  - A legal store whose word address equals the youngest entry merges into that entry. This applies only when the youngest entry is not the head, i.e. count ≥ 2.
  - Merge rule: be_new = be_old | be_in; byte lanes set in be_in are replaced; count is unchanged.
  - st_ready = (count < DEPTH) || merge_hit, where merge_hit is computed from st_addr/st_size.
- Undefined: no merging; every legal store occupies its own entry.

Test Plan:
- sb st_addr = 0x1003, st_data = 0x000000AB, empty buffer -> next cycle mem_we = 1, mem_addr = 0x400, mem_be = 1000, mem_wdata = 0xABABABAB; ack -> empty = 1.
- sh at 0x2002 with data 0x1234, then sw at 0x2004 with data 0xDEADBEEF, mem_ack held low 5 cycles:
  - st_ready = 0 after the second accept.
  - Outputs hold the sh entry (be = 1100, wdata = 0x12341234).
  - After ack the sw entry is presented.
- sw at 0x3001 -> misalign_err pulses 1 cycle; mem_we stays 0; count = 0. Repeat with sh at 0x3003 and with st_size = 11 -> same.
- Buffer holds a store to 0x4008; ld_addr = 0x400B with ld_valid = 1 -> ld_hazard = 1; ld_addr = 0x400C -> 0; ld_valid = 0 -> 0.
- Full buffer, mem_ack asserted while st_valid = 1 -> no accept that cycle; accepted the next cycle; order preserved. rst_n low mid-drain -> all outputs return to reset values immediately.
- With STORE_ALIGN_MERGE_EN: hold mem_ack = 0 while buffer holds sw 0x5000 then sb 0x5004 (data 0x11); then sb 0x5005 (data 0x22) -> merges into the 0x5004 entry, giving be = 0011 and bytes [15:0] = 0x2211.

Source files
------------

// File: rtl/store_align_buffer.sv
// Store alignment buffer: encodes sb/sh/sw into byte enables and replicated data,
// queues legal stores and drains them to data memory. Optional macro: STORE_ALIGN_MERGE_EN.
module store_align_buffer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        misalign_err,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [29:0]      r_addr  [DEPTH];
    logic [31:0]      r_wdata [DEPTH];
    logic [3:0]       r_be    [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_misalign;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_bad;
    logic        w_full;
    logic        w_merge_hit;
    logic        w_accept;
    logic        w_push;
    logic        w_merge;
    logic        w_pop;
    logic        w_hazard;
    logic        w_unused_ok;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = st_data;
        w_bad   = 1'b0;
        case (st_size)
            2'b00: begin
                w_be    = 4'b0001 << st_addr[1:0];
                w_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{st_data[15:0]}};
                w_bad   = st_addr[0];
            end
            2'b10: begin
                w_be  = 4'b1111;
                w_bad = (st_addr[1:0] != 2'b00);
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign w_full = (r_count == CNT_W'(DEPTH));

`ifdef STORE_ALIGN_MERGE_EN
    logic [PTR_W-1:0] w_youngest;
    assign w_youngest  = r_tail - PTR_W'(1);
    // Never merge into the head: it may be on the memory bus right now.
    assign w_merge_hit = !w_bad && (r_count >= CNT_W'(2)) &&
                         (r_addr[w_youngest] == st_addr[31:2]);
    assign st_ready    = !w_full || w_merge_hit;
`else
    assign w_merge_hit = 1'b0;
    assign st_ready    = !w_full;
`endif

    assign w_accept = st_valid && st_ready;
    assign w_push   = w_accept && !w_bad && !w_merge_hit;
    assign w_merge  = w_accept && w_merge_hit;
    assign w_pop    = mem_we && mem_ack;

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == ld_addr[31:2])) w_hazard = 1'b1;
        end
    end

    assign ld_hazard   = ld_valid && w_hazard;
    assign w_unused_ok = &{1'b0, ld_addr[1:0]};

    assign mem_we       = (r_count != '0);
    assign mem_addr     = mem_we ? r_addr[r_head]  : 30'd0;
    assign mem_wdata    = mem_we ? r_wdata[r_head] : 32'd0;
    assign mem_be       = mem_we ? r_be[r_head]    : 4'd0;
    assign empty        = (r_count == '0);
    assign misalign_err = r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
                r_be[i]    <= '0;
            end
            r_valid    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_accept && w_bad;
            // Push and pop never touch the same slot: a full buffer refuses pushes.
            if (w_push) begin
                r_addr[r_tail]  <= st_addr[31:2];
                r_wdata[r_tail] <= w_wdata;
                r_be[r_tail]    <= w_be;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
`ifdef STORE_ALIGN_MERGE_EN
            if (w_merge) begin
                r_be[w_youngest] <= r_be[w_youngest] | w_be;
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) r_wdata[w_youngest][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
`endif
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef STORE_ALIGN_MERGE_EN
    logic w_unused_merge;
    assign w_unused_merge = w_merge;
`endif

endmodule
